// File: rtl/alu_pkg.sv
// Shared ALU opcode definitions used by the datapath and the multiply/divide unit.
package alu_pkg;

    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] OPMULT  = 5'd10;
    localparam logic [ALU_OP_W-1:0] OPMULTU = 5'd11;
    localparam logic [ALU_OP_W-1:0] OPDIV   = 5'd12;
    localparam logic [ALU_OP_W-1:0] OPDIVU  = 5'd13;
    localparam logic [ALU_OP_W-1:0] OPMTHI  = 5'd14;
    localparam logic [ALU_OP_W-1:0] OPMTLO  = 5'd15;

endpackage

// File: rtl/mdu_pkg.sv
// Shared types for the multiply/divide unit: FSM states and iteration count.
// Optional single-cycle multiply is selected with macro MDU_FAST_MULT_EN.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam int MDU_ITERATIONS = 32;
    localparam int MDU_CNT_W      = 5;

endpackage

// File: rtl/mult_div_unit_if.sv
// Command/result bundle between the pipeline (master) and the multiply/divide unit (slave).
interface mult_div_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  iStart;
    logic [4:0]            iControlSignal;
    logic [DATA_WIDTH-1:0] iA;
    logic [DATA_WIDTH-1:0] iB;
    logic                  oBusy;
    logic                  oDone;
    logic                  oDivByZero;
    logic [DATA_WIDTH-1:0] oHI;
    logic [DATA_WIDTH-1:0] oLO;

    modport master (
        output iStart, iControlSignal, iA, iB,
        input  oBusy, oDone, oDivByZero, oHI, oLO
    );

    modport slave (
        input  iStart, iControlSignal, iA, iB,
        output oBusy, oDone, oDivByZero, oHI, oLO
    );
endinterface

// File: rtl/mdu_divider.sv
// One restoring-division step on unsigned magnitudes: shift the next dividend
// bit into the remainder, subtract the divisor, keep the difference if it fits.
module mdu_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_i,
    input  logic [DATA_WIDTH-1:0] quo_i,
    input  logic [DATA_WIDTH-1:0] divisor_i,
    output logic [DATA_WIDTH-1:0] rem_o,
    output logic [DATA_WIDTH-1:0] quo_o
);

    logic [DATA_WIDTH:0] shifted;
    logic [DATA_WIDTH:0] diff;

    // The remainder stays below the divisor, so a set MSB in diff means borrow.
    always_comb begin
        shifted = {rem_i, quo_i[DATA_WIDTH-1]};
        diff    = shifted - {1'b0, divisor_i};
        if (!diff[DATA_WIDTH]) begin
            rem_o = diff[DATA_WIDTH-1:0];
        end else begin
            rem_o = shifted[DATA_WIDTH-1:0];
        end
        quo_o = {quo_i[DATA_WIDTH-2:0], ~diff[DATA_WIDTH]};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Define MDU_FAST_MULT_EN to replace the 32-step multiply with a single-cycle multiplier.
module mult_div_unit
    import alu_pkg::*;
    import mdu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic         iCLK,
    input  logic         iRST_n,
    mult_div_unit_if.slave bus
);

    localparam int W = DATA_WIDTH;

    mdu_state_e             state_q, state_d;
    logic [MDU_CNT_W-1:0]   cnt_q, cnt_d;
    logic [4:0]             op_q, op_d;
    logic [2*W-1:0]         work_q, work_d;
    logic [W-1:0]           opb_q, opb_d;
    logic                   neg_lo_q, neg_lo_d;
    logic                   neg_hi_q, neg_hi_d;
    logic [W-1:0]           hi_q, hi_d;
    logic [W-1:0]           lo_q, lo_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   dbz_q, dbz_d;

    logic                   in_signed, a_neg, b_neg;
    logic [W-1:0]           a_mag, b_mag;
    logic                   op_is_mult;
    logic [W:0]             mul_sum;
    logic [2*W-1:0]         mul_next;
    logic [W-1:0]           div_rem, div_quo;

    mdu_divider #(.DATA_WIDTH(W)) u_divider (
        .rem_i     (work_q[2*W-1:W]),
        .quo_i     (work_q[W-1:0]),
        .divisor_i (opb_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );

    // Operands are reduced to magnitudes; the sign is reapplied in FIX.
    assign in_signed  = (bus.iControlSignal == OPMULT) || (bus.iControlSignal == OPDIV);
    assign a_neg      = in_signed && bus.iA[W-1];
    assign b_neg      = in_signed && bus.iB[W-1];
    assign a_mag      = a_neg ? -bus.iA : bus.iA;
    assign b_mag      = b_neg ? -bus.iB : bus.iB;
    assign op_is_mult = (op_q == OPMULT) || (op_q == OPMULTU);

    // Shift-add step: upper half accumulates, multiplier bits leave from the bottom.
    assign mul_sum  = {1'b0, work_q[2*W-1:W]} + {1'b0, (work_q[0] ? opb_q : {W{1'b0}})};
    assign mul_next = {mul_sum, work_q[W-1:1]};

`ifdef MDU_FAST_MULT_EN
    logic [2*W-1:0] fast_a, fast_b, fast_prod;
    logic           fast_signed;

    assign fast_signed = (op_q == OPMULT);
    assign fast_a      = {{W{fast_signed & work_q[2*W-1]}}, work_q[2*W-1:W]};
    assign fast_b      = {{W{fast_signed & work_q[W-1]}}, work_q[W-1:0]};
    assign fast_prod   = fast_a * fast_b;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        work_d   = work_q;
        opb_d    = opb_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dbz_d    = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.iStart) begin
                    op_d  = bus.iControlSignal;
                    cnt_d = '0;
                    case (bus.iControlSignal)
                        OPMULT, OPMULTU: begin
`ifdef MDU_FAST_MULT_EN
                            work_d  = {bus.iA, bus.iB};
                            state_d = FIX;
`else
                            opb_d    = a_mag;
                            work_d   = {{W{1'b0}}, b_mag};
                            neg_lo_d = a_neg ^ b_neg;
                            state_d  = RUN;
`endif
                        end
                        OPDIV, OPDIVU: begin
                            if (bus.iB == '0) begin
                                dbz_d   = 1'b1;
                                state_d = DONE;
                            end else begin
                                work_d   = {{W{1'b0}}, a_mag};
                                opb_d    = b_mag;
                                neg_lo_d = a_neg ^ b_neg;
                                neg_hi_d = a_neg;
                                state_d  = RUN;
                            end
                        end
                        OPMTHI: hi_d = bus.iA;
                        OPMTLO: lo_d = bus.iA;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                work_d = op_is_mult ? mul_next : {div_rem, div_quo};
                cnt_d  = cnt_q + MDU_CNT_W'(1);
                if (cnt_q == MDU_CNT_W'(MDU_ITERATIONS - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_is_mult) begin
`ifdef MDU_FAST_MULT_EN
                    {hi_d, lo_d} = fast_prod;
`else
                    {hi_d, lo_d} = neg_lo_q ? -work_q : work_q;
`endif
                end else begin
                    lo_d = neg_lo_q ? -work_q[W-1:0] : work_q[W-1:0];
                    hi_d = neg_hi_q ? -work_q[2*W-1:W] : work_q[2*W-1:W];
                end
                state_d = DONE;
            end
        endcase

        busy_d = (state_d == RUN) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            work_q   <= '0;
            opb_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            work_q   <= work_d;
            opb_q    <= opb_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dbz_q    <= dbz_d;
        end
    end

    assign bus.oBusy      = busy_q;
    assign bus.oDone      = done_q;
    assign bus.oDivByZero = dbz_q;
    assign bus.oHI        = hi_q;
    assign bus.oLO        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed-vector bench for mult_div_unit; latency expectations follow MDU_FAST_MULT_EN.
module tb_mult_div_unit;
    import alu_pkg::*;

    localparam int DIV_LAT = 33;
`ifdef MDU_FAST_MULT_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk;
    logic rst_n;
    int   total_count;
    int   bad_count;

    mult_div_unit_if #(.DATA_WIDTH(32)) bus ();

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .iCLK   (clk),
        .iRST_n (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total_count++;
        if (got !== want) begin
            bad_count++;
            $display("[TB] FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Present a one-cycle command; returns in the cycle after the accepting edge.
    task automatic applyStimulus(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.iStart         = 1'b1;
        bus.iControlSignal = op;
        bus.iA             = a;
        bus.iB             = b;
        @(posedge clk);
        @(negedge clk);
        bus.iStart = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        while (bus.oDone !== 1'b1 && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic runAndCheck(input string tag, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input int lat, input logic [31:0] hi,
                               input logic [31:0] lo, input logic dbz);
        int cycles;
        applyStimulus(op, a, b);
        checkOutput({tag, ".busy"}, 64'(bus.oBusy), 64'(lat > 0));
        waitDone(cycles);
        checkOutput({tag, ".lat"}, 64'(cycles), 64'(lat));
        checkOutput({tag, ".hi"}, 64'(bus.oHI), 64'(hi));
        checkOutput({tag, ".lo"}, 64'(bus.oLO), 64'(lo));
        checkOutput({tag, ".dbz"}, 64'(bus.oDivByZero), 64'(dbz));
        checkOutput({tag, ".busy_at_done"}, 64'(bus.oBusy), 64'(0));
        @(negedge clk);
        checkOutput({tag, ".pulse"}, 64'(bus.oDone), 64'(0));
    endtask

    initial begin
        int cycles;
        total_count        = 0;
        bad_count          = 0;
        rst_n              = 1'b0;
        bus.iStart         = 1'b0;
        bus.iControlSignal = '0;
        bus.iA             = '0;
        bus.iB             = '0;

        repeat (2) @(negedge clk);
        checkOutput("rst.hi", 64'(bus.oHI), 64'(0));
        checkOutput("rst.lo", 64'(bus.oLO), 64'(0));
        checkOutput("rst.busy", 64'(bus.oBusy), 64'(0));
        checkOutput("rst.done", 64'(bus.oDone), 64'(0));
        checkOutput("rst.dbz", 64'(bus.oDivByZero), 64'(0));
        rst_n = 1'b1;

        runAndCheck("multu_max", OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT,
                    32'hFFFFFFFE, 32'h00000001, 1'b0);
        runAndCheck("mult_neg", OPMULT, 32'hFFFFFFFD, 32'h00000007, MUL_LAT,
                    32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
        runAndCheck("div_neg", OPDIV, 32'hFFFFFFF9, 32'h00000002, DIV_LAT,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
        runAndCheck("div_ovf", OPDIV, 32'h80000000, 32'hFFFFFFFF, DIV_LAT,
                    32'h00000000, 32'h80000000, 1'b0);
        runAndCheck("divu", OPDIVU, 32'd1000, 32'd7, DIV_LAT, 32'd6, 32'd142, 1'b0);

        applyStimulus(OPMTHI, 32'h11, 32'h0);
        checkOutput("mthi11.hi", 64'(bus.oHI), 64'h11);
        applyStimulus(OPMTLO, 32'h22, 32'h0);
        checkOutput("mtlo22.lo", 64'(bus.oLO), 64'h22);
        checkOutput("mtlo22.busy", 64'(bus.oBusy), 64'(0));
        checkOutput("mtlo22.done", 64'(bus.oDone), 64'(0));

        runAndCheck("divu_zero", OPDIVU, 32'd100, 32'd0, 0, 32'h11, 32'h22, 1'b1);

        applyStimulus(OPMTHI, 32'hCAFEF00D, 32'h0);
        checkOutput("mthi.hi", 64'(bus.oHI), 64'hCAFEF00D);
        checkOutput("mthi.lo", 64'(bus.oLO), 64'h22);
        checkOutput("mthi.busy", 64'(bus.oBusy), 64'(0));
        checkOutput("mthi.done", 64'(bus.oDone), 64'(0));

        // A DIV by zero arriving mid-operation must be dropped along with the operand churn.
        applyStimulus(OPDIVU, 32'd1000, 32'd3);
        repeat (4) @(negedge clk);
        bus.iStart         = 1'b1;
        bus.iControlSignal = OPDIV;
        bus.iA             = 32'd7;
        bus.iB             = 32'd0;
        @(negedge clk);
        bus.iStart = 1'b0;
        bus.iA     = 32'd55;
        bus.iB     = 32'd9;
        waitDone(cycles);
        checkOutput("ignore.lat", 64'(cycles + 5), 64'(DIV_LAT));
        checkOutput("ignore.lo", 64'(bus.oLO), 64'd333);
        checkOutput("ignore.hi", 64'(bus.oHI), 64'd1);
        checkOutput("ignore.dbz", 64'(bus.oDivByZero), 64'(0));
        @(negedge clk);
        checkOutput("ignore.idle", 64'(bus.oBusy), 64'(0));

        applyStimulus(OPDIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst.busy", 64'(bus.oBusy), 64'(0));
        checkOutput("midrst.hi", 64'(bus.oHI), 64'(0));
        checkOutput("midrst.lo", 64'(bus.oLO), 64'(0));
        @(negedge clk);
        checkOutput("midrst.done", 64'(bus.oDone), 64'(0));
        rst_n = 1'b1;
        runAndCheck("post_rst_multu", OPMULTU, 32'd3, 32'd5, MUL_LAT, 32'd0, 32'd15, 1'b0);

        $display("test done: total=%0d bad=%0d", total_count, bad_count);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 SHALL have port iCLK  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port iRST_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port iStart  input  1  command strobe, sampled each rising edge.
REQ-005 SHALL have port iControlSignal  input  5  ALU control code: OPMULT, OPMULTU, OPDIV, OPDIVU, OPMTHI or OPMTLO.
REQ-006 SHALL have ports iA, iB  input  32 each  operands: dividend/multiplicand and divisor/multiplier; iA is the MTHI/MTLO source.
REQ-007 SHALL have port oBusy  output  1  operation in progress.
REQ-008 SHALL have port oDone  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports oHI, oLO  output  32 each  architectural HI/LO registers.
REQ-010 SHALL have port oDivByZero  output  1  valid with oDone; set when the completed divide had iB=0.

Function
REQ-011 SHALL use states IDLE, RUN, FIX, DONE; iStart is accepted only in IDLE or DONE and ignored elsewhere.
REQ-012 SHALL, on an accepted iStart at edge N: latch iA, iB and opcode; enter RUN; assert oBusy from the cycle after edge N.
REQ-013 SHALL iterate in RUN one bit per edge, N+1..N+32, using a 5-bit counter (shift-add multiply, restoring divide); then enter FIX.
REQ-014 SHALL in FIX (edge N+33) apply sign correction, write HI/LO, enter DONE; in DONE, oDone=1 and oBusy=0 for exactly one cycle.
REQ-015 SHALL compute MULT/MULTU as the 64-bit signed/unsigned product {HI,LO}.
REQ-016 SHALL compute DIV/DIVU with LO=quotient truncated toward zero and HI=remainder carrying the dividend's sign; DIV 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-017 SHALL, for DIV/DIVU with iB=0: skip RUN/FIX, go to DONE at edge N, leave HI/LO unchanged and assert oDivByZero with oDone.
REQ-018 SHALL, for OPMTHI/OPMTLO accepted at edge N, write iA to HI/LO at that edge, stay in IDLE, and produce no oBusy or oDone.
REQ-019 SHALL treat any other iControlSignal with iStart as a no-op.
REQ-020 SHALL ignore iA/iB/iControlSignal changes while oBusy=1.

Reset
REQ-021 SHALL, on iRST_n low at any time including mid-operation, force IDLE, oBusy=0, oDone=0, oDivByZero=0, oHI=0, oLO=0 and counter=0, and discard the operation in flight.
REQ-022 SHALL accept iStart on the first rising edge after iRST_n deasserts.

Configuration
REQ-023 SHALL support macro MDU_FAST_MULT_EN: when defined, MULT/MULTU use a single-cycle 64-bit multiplier, write HI/LO at edge N+1, and assert oDone in the following cycle; when undefined, multiply follows REQ-013/014; divide timing is unaffected either way.

Structure
REQ-024 SHALL take opcode constants (OPMULT...OPMTLO) from the shared ALU opcode definitions; state encodings and the iteration count (32) SHALL live in shared package mdu_pkg.
REQ-025 SHALL place the restoring-division step datapath (remainder/quotient shift-subtract) in sub-module mdu_divider; the FSM, multiplier and HI/LO stay in mult_div_unit.

Verification
REQ-026 SHALL cover: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; oDone in the cycle after edge N+33 (macro undefined), after edge N+1 (macro defined).
REQ-027 SHALL cover: MULT 0xFFFFFFFD x 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-028 SHALL cover: DIV 0xFFFFFFF9 / 0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-029 SHALL cover: DIVU 100 / 0 with prior HI=0x11, LO=0x22 -> oDone and oDivByZero in the cycle after edge N; HI/LO unchanged.
REQ-030 SHALL cover: MTHI 0xCAFEF00D in IDLE -> oHI=0xCAFEF00D next cycle; iStart with DIV during oBusy -> ignored, running result unaffected.
REQ-031 SHALL cover: iRST_n low at edge N+10 of a DIVU -> oBusy=0, HI=LO=0 immediately; a new MULTU 3x5 after release -> LO=15, HI=0.
